// File: rtl/fifo_word_packer_pkg.sv
// Shared constants, types and helpers for the FIFO word packer.
// Optional idle auto-flush is enabled with the FIFO_WORD_PACKER_TIMEOUT_EN macro.
package fifo_word_packer_pkg;

    // Default geometry: 8-bit bytes packed four to a word.
    localparam int DW_DEF    = 8;
    localparam int BYTES_DEF = 4;
    localparam int LANE_W    = DW_DEF;

    // Widest lane mask the helper below can build.
    localparam int MAX_LANES = 32;

    // Lane-enable mask for the default word geometry.
    typedef logic [BYTES_DEF-1:0] obe_t;

    // Debug state encoding, visible on dbg_state_o.
    localparam logic [1:0] ST_IDLE      = 2'b00;  // nothing held, output slot empty
    localparam logic [1:0] ST_FILL      = 2'b01;  // partial word accumulating
    localparam logic [1:0] ST_FULL_HOLD = 2'b10;  // word presented, downstream stalling

    // Mask with the low 'count' lanes set; callers truncate to their lane count.
    function automatic logic [MAX_LANES-1:0] obe_mask(input int unsigned count);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Output holding register for the word packer: captures a word and its lane
// enables on load and keeps them stable until the downstream accepts.
module packer_out_reg #(
    parameter int WW    = 32,
    parameter int BYTES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WW-1:0]    word_i,
    input  logic [BYTES-1:0] be_i,
    input  logic             oready_i,
    output logic             ovalid_o,
    output logic [WW-1:0]    dout_o,
    output logic [BYTES-1:0] obe_o
);

    logic             ovalid_q;
    logic [WW-1:0]    dout_q;
    logic [BYTES-1:0] obe_q;

    // Load has priority; a load only happens when the slot is free, so it
    // never overwrites a word the downstream has not taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovalid_q <= 1'b0;
            dout_q   <= '0;
            obe_q    <= '0;
        end else if (load_i) begin
            ovalid_q <= 1'b1;
            dout_q   <= word_i;
            obe_q    <= be_i;
        end else if (ovalid_q && oready_i) begin
            ovalid_q <= 1'b0;
        end
    end

    assign ovalid_o = ovalid_q;
    assign dout_o   = dout_q;
    assign obe_o    = obe_q;

endmodule

// File: rtl/fifo_word_packer.sv
// FIFO word packer: packs BYTES little-endian bytes from the FIFO read side
// into one word with per-lane enables; a flush pulse pushes out a partial word.
// Define FIFO_WORD_PACKER_TIMEOUT_EN to auto-flush after TIMEOUT idle cycles.
//
// Handshake: both sides are valid/ready. A byte moves on a rising edge with
// ivalid && iready; a word moves on a rising edge with ovalid && oready.
// iready = !ovalid || oready, so a byte may enter in the same edge the held
// word leaves. ovalid/dout/obe are registered and never depend on oready.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int BYTES   = BYTES_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                         clkout,
    input  logic                         rstout_n,
    input  logic                         ivalid,
    output logic                         iready,
    input  logic [DW-1:0]                din,
    input  logic                         flush,
    output logic                         ovalid,
    input  logic                         oready,
    output logic [DW*BYTES-1:0]          dout,
    output logic [BYTES-1:0]             obe,
    output logic [$clog2(BYTES+1)-1:0]   fill,
    output logic [1:0]                   dbg_state_o
);

    localparam int CW = $clog2(BYTES+1);
    localparam int WW = DW * BYTES;

    // Reject geometries the packer cannot represent.
    if (BYTES < 2 || BYTES > MAX_LANES || TIMEOUT < 1) begin : g_param_check
        $error("fifo_word_packer: BYTES must be 2..32 and TIMEOUT at least 1");
    end

    logic [CW-1:0]    cnt_q, cnt_d, cnt_plus;
    logic [WW-1:0]    acc_q, acc_d, acc_next;
    logic             pend_q, pend_d, pend_eff;
    logic             slot_free, accept, complete, service, load;
    logic             tmo_hit;
    logic [WW-1:0]    load_word;
    logic [BYTES-1:0] load_be;

    assign slot_free = !ovalid || oready;
    assign iready    = slot_free;
    assign accept    = ivalid && slot_free;
    assign cnt_plus  = cnt_q + CW'(accept);
    assign complete  = accept && (cnt_q == CW'(BYTES-1));

    // A pending flush (including one arriving this cycle) is serviced as soon
    // as the output slot can take a word; with nothing held it simply clears.
    assign pend_eff  = pend_q || flush || tmo_hit;
    assign service   = pend_eff && slot_free;
    assign load      = complete || (service && (cnt_plus != '0));

    // Drop the accepted byte into lane cnt of the accumulator.
    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < BYTES; i++) begin
            if (accept && (cnt_q == CW'(i))) begin
                acc_next[i*DW +: DW] = din;
            end
        end
    end

    // Build the outgoing word: lanes beyond the byte count are forced to zero.
    always_comb begin
        load_be   = BYTES'(obe_mask(32'(cnt_plus)));
        load_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            load_word[i*DW +: DW] = acc_next[i*DW +: DW] & {DW{load_be[i]}};
        end
    end

    // Next-state for the byte counter, accumulator and flush-pending flag.
    always_comb begin
        cnt_d  = load ? '0 : cnt_plus;
        acc_d  = load ? '0 : acc_next;
        pend_d = service ? 1'b0 : pend_eff;
    end

    // Accumulator state; reset discards any bytes held.
    always_ff @(posedge clkout or negedge rstout_n) begin
        if (!rstout_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            pend_q <= pend_d;
        end
    end

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT+1);

    logic [IW-1:0] idle_q, idle_d;

    // Saturating at TIMEOUT keeps the request asserted until it can be serviced.
    assign tmo_hit = (idle_q == IW'(TIMEOUT));

    // Count cycles spent holding a partial word with no new byte arriving.
    always_comb begin
        idle_d = idle_q;
        if (accept || load) begin
            idle_d = '0;
        end else if ((cnt_q != '0) && !tmo_hit) begin
            idle_d = idle_q + IW'(1);
        end
    end

    // Idle timer register.
    always_ff @(posedge clkout or negedge rstout_n) begin
        if (!rstout_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    packer_out_reg #(
        .WW    (WW),
        .BYTES (BYTES)
    ) u_out_reg (
        .clk_i    (clkout),
        .rst_ni   (rstout_n),
        .load_i   (load),
        .word_i   (load_word),
        .be_i     (load_be),
        .oready_i (oready),
        .ovalid_o (ovalid),
        .dout_o   (dout),
        .obe_o    (obe)
    );

    assign fill = cnt_q;

    // Debug view of the packer state.
    always_comb begin
        if (ovalid && !oready) begin
            dbg_state_o = ST_FULL_HOLD;
        end else if (cnt_q != '0) begin
            dbg_state_o = ST_FILL;
        end else begin
            dbg_state_o = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: directed scenarios followed by random
// traffic, all compared against a byte-queue reference model.
module tb_fifo_word_packer;
    import fifo_word_packer_pkg::*;

    localparam int DW      = 8;
    localparam int BYTES   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(BYTES+1);

    // ---------------- clock / reset ----------------
    logic clkout   = 1'b0;
    logic rstout_n = 1'b0;
    always #5 clkout = ~clkout;

    logic              ivalid = 1'b0;
    logic              iready;
    logic [DW-1:0]     din    = '0;
    logic              flush  = 1'b0;
    logic              ovalid;
    logic              oready = 1'b0;
    logic [DW*BYTES-1:0] dout;
    logic [BYTES-1:0]  obe;
    logic [CW-1:0]     fill;
    logic [1:0]        dbg_state;

    fifo_word_packer #(
        .DW      (DW),
        .BYTES   (BYTES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clkout      (clkout),
        .rstout_n    (rstout_n),
        .ivalid      (ivalid),
        .iready      (iready),
        .din         (din),
        .flush       (flush),
        .ovalid      (ovalid),
        .oready      (oready),
        .dout        (dout),
        .obe         (obe),
        .fill        (fill),
        .dbg_state_o (dbg_state)
    );

    int passed = 0;
    int total  = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0]       m_bytes[$];
    logic                m_ovalid;
    logic [DW*BYTES-1:0] m_dout;
    obe_t                m_obe;
    bit                  m_pend;
    int                  m_idle;

    task automatic model_reset();
        m_bytes.delete();
        m_ovalid = 1'b0;
        m_dout   = '0;
        m_obe    = '0;
        m_pend   = 1'b0;
        m_idle   = 0;
    endtask

    task automatic model_emit();
        m_dout = '0;
        for (int i = 0; i < m_bytes.size(); i++) m_dout[i*DW +: DW] = m_bytes[i];
        m_obe    = obe_t'((1 << m_bytes.size()) - 1);
        m_ovalid = 1'b1;
        m_bytes.delete();
    endtask

    // One rising edge, evaluated from the inputs that were stable before it.
    task automatic model_edge();
        bit slot, acc, pend, emitted;
        int n_before;
        n_before = m_bytes.size();
        slot     = !m_ovalid || oready;
        acc      = ivalid && slot;
        pend     = m_pend || flush;
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
        if (m_idle >= TIMEOUT) pend = 1'b1;
`endif
        emitted = 1'b0;
        if (m_ovalid && oready) m_ovalid = 1'b0;
        if (acc) m_bytes.push_back(din);
        if (m_bytes.size() == BYTES) begin
            model_emit();
            emitted = 1'b1;
        end
        if (pend && slot) begin
            if (!emitted && m_bytes.size() > 0) begin
                model_emit();
                emitted = 1'b1;
            end
            pend = 1'b0;
        end
        m_pend = pend;
        if (acc || emitted) m_idle = 0;
        else if (n_before > 0 && m_idle < TIMEOUT) m_idle++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        logic [1:0] exp_state;
        if (m_ovalid && !oready)   exp_state = ST_FULL_HOLD;
        else if (m_bytes.size()>0) exp_state = ST_FILL;
        else                       exp_state = ST_IDLE;
        check("ovalid", 64'(ovalid), 64'(m_ovalid));
        check("iready", 64'(iready), 64'(!m_ovalid || oready));
        check("fill",   64'(fill),   64'(m_bytes.size()));
        check("state",  64'(dbg_state), 64'(exp_state));
        if (m_ovalid) begin
            check("dout", 64'(dout), 64'(m_dout));
            check("obe",  64'(obe),  64'(m_obe));
        end
        if (!rstout_n) begin
            check("rst_dout", 64'(dout), 64'd0);
            check("rst_obe",  64'(obe),  64'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clkout);
        if (!rstout_n) model_reset();
        else model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
        ivalid = v;
        din    = d;
        flush  = f;
        oready = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit got;
        model_reset();

        // Reset held, then released with no traffic.
        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (3) tick();
        rstout_n = 1'b1;
        repeat (2) tick();
        check("idle_iready", 64'(iready), 64'd1);

        // Four bytes back-to-back form one full word.
        drive(1'b1, 8'h01, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h02, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h03, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h04, 1'b0, 1'b1); tick();
        check("w0_valid", 64'(ovalid), 64'd1);
        check("w0_dout",  64'(dout),   64'h04030201);
        check("w0_obe",   64'(obe),    64'hF);
        drive(1'b0, '0, 1'b0, 1'b1); tick();
        check("w0_gone",  64'(ovalid), 64'd0);

        // Two bytes then a flush pulse.
        drive(1'b1, 8'h11, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h22, 1'b0, 1'b1); tick();
        drive(1'b0, '0, 1'b1, 1'b1); tick();
        check("fl_dout", 64'(dout), 64'h00002211);
        check("fl_obe",  64'(obe),  64'h3);
        check("fl_fill", 64'(fill), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b1); tick();

        // Full word stalled downstream; next byte is held off, then enters on transfer.
        drive(1'b1, 8'hC1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC2, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC3, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC4, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
        check("stall_iready", 64'(iready), 64'd0);
        check("stall_fill",   64'(fill),   64'd0);
        tick();
        check("stall_dout",   64'(dout),   64'hC4C3C2C1);
        drive(1'b1, 8'h55, 1'b0, 1'b1); tick();
        check("xfer_fill",  64'(fill),   64'd1);
        check("xfer_valid", 64'(ovalid), 64'd0);

        // Flush the lone byte, then flush with nothing held.
        drive(1'b0, '0, 1'b1, 1'b1); tick();
        check("one_dout", 64'(dout), 64'h00000055);
        check("one_obe",  64'(obe),  64'h1);
        drive(1'b0, '0, 1'b0, 1'b1); tick();
        drive(1'b0, '0, 1'b1, 1'b1); tick();
        check("empty_flush", 64'(ovalid), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b1); tick();
        check("empty_flush2", 64'(ovalid), 64'd0);

        // Flush coincident with the completing byte yields a single full word.
        drive(1'b1, 8'h41, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h42, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h43, 1'b0, 1'b1); tick();
        drive(1'b1, 8'h44, 1'b1, 1'b1); tick();
        check("co_dout", 64'(dout), 64'h44434241);
        check("co_obe",  64'(obe),  64'hF);
        drive(1'b0, '0, 1'b0, 1'b1); tick();
        check("co_single", 64'(ovalid), 64'd0);
        tick();
        check("co_single2", 64'(ovalid), 64'd0);

        // Asynchronous reset in the middle of a word.
        drive(1'b1, 8'hB1, 1'b0, 1'b1); tick();
        drive(1'b1, 8'hB2, 1'b0, 1'b1); tick();
        check("pre_rst_fill", 64'(fill), 64'd2);
        drive(1'b0, '0, 1'b0, 1'b1);
        #2 rstout_n = 1'b0;
        #1;
        model_reset();
        check("async_fill",  64'(fill),   64'd0);
        check("async_valid", 64'(ovalid), 64'd0);
        repeat (2) tick();
        rstout_n = 1'b1;
        drive(1'b1, 8'hA1, 1'b0, 1'b1); tick();
        drive(1'b1, 8'hA2, 1'b0, 1'b1); tick();
        drive(1'b1, 8'hA3, 1'b0, 1'b1); tick();
        drive(1'b1, 8'hA4, 1'b0, 1'b1); tick();
        check("post_rst_dout", 64'(dout), 64'hA4A3A2A1);
        drive(1'b0, '0, 1'b0, 1'b1); tick();

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
        // A lone byte is pushed out once the idle timer expires.
        drive(1'b1, 8'h5A, 1'b0, 1'b1); tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (ovalid) got = 1'b1;
        end
        check("tmo_seen", 64'(got), 64'd1);
        check("tmo_dout", 64'(dout), 64'h0000005A);
        check("tmo_obe",  64'(obe),  64'h1);
        tick();
`endif

        // Random traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the async FIFO, clocked in the FIFO read domain.
- Takes the FIFO's 8-bit valid/ready byte stream and packs BYTES bytes into one word, little-endian.
- Presents each word on a registered valid/ready output with a per-byte-lane enable mask.
- A partial word can be forced out by a flush request.

Parameters:
- DW, 8: input byte width; must match FIFO data width.
- BYTES, 4: bytes per output word; must be 2 or more.
- TIMEOUT, 16: idle cycles before auto-flush; used only with the optional feature.

Ports:
- clkout  in  1  read-domain clock, shared with the FIFO read side.
- rstout_n  in  1  asynchronous active-low reset.
- ivalid  in  1  byte valid; driven by the FIFO ovalid.
- iready  out  1  byte accept; drives the FIFO oready.
- din  in  DW  byte from the FIFO dout.
- flush  in  1  single-cycle request to emit a partial word.
- ovalid  out  1  output word valid.
- oready  in  1  downstream accept.
- dout  out  DW*BYTES  packed word; byte 0 sits in bits [DW-1:0].
- obe  out  BYTES  lane enables; bit i set means byte i is valid.
- fill  out  clog2(BYTES+1)  bytes held in the accumulator.

Behaviour:
- Reset:
  - Asserting rstout_n low clears state immediately, without waiting for a clock.
  - Cleared to zero: ovalid, dout, obe, fill, byte counter, flush-pending flag and idle timer.
  - Bytes held in the accumulator are discarded.
  - After release, iready is 1 on the first clock.
- Handshake:
  - iready = !ovalid || oready. A byte is accepted when ivalid && iready at a rising edge.
  - A word transfers out when ovalid && oready at a rising edge.
  - ovalid, dout and obe are held stable until transfer; none depend combinationally on oready.
- Accumulation:
  - An accepted byte is written to lane cnt and cnt increments.
  - A byte taking cnt to BYTES completes the word. At that edge dout, obe and ovalid are loaded, and cnt wraps to 0.
  - Latency: completing byte accepted at edge k gives ovalid=1 in the cycle after edge k.
  - Back-to-back words are supported: with oready held at 1, the word transfers and the next word's first byte is accepted at the same edge.
- Flush:
  - flush sets flush-pending.
  - Pending is serviced at the first edge where the output slot is free (!ovalid || oready).
  - Service when cnt>0, or when a byte is accepted in that edge: emit the partial word.
    - Includes any byte accepted at that same edge.
    - obe = low (cnt) bits set; unused lanes of dout are 0.
    - cnt goes to 0.
  - Service when cnt==0 and no byte is accepted: nothing is emitted; pending clears.
  - Completing byte and flush at the same edge: a full word is emitted (obe all ones) and pending clears.
  - Repeated flush pulses while pending are absorbed; at most one partial word is emitted.
- States:
  - IDLE (cnt=0, ovalid=0).
  - FILL (0<cnt<BYTES).
  - FULL_HOLD (ovalid=1 && !oready).
  - Transitions follow the accept, transfer and flush rules above.
  - fill equals cnt at all times.

Optional Feature:
- Macro: FIFO_WORD_PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle where cnt>0 and no byte is accepted.
  - It clears on any accepted byte or on any emitted word.
  - Reaching TIMEOUT sets flush-pending exactly as a flush pulse does.
- Undefined: no counter logic; partial words leave only via flush.

Decomposition:
- Package fifo_word_packer_pkg holds:
  - DW and BYTES defaults, the lane width constant and the BYTES-wide obe type;
  - the state encoding IDLE/FILL/FULL_HOLD;
  - a function giving the obe mask from a count.
- One sub-module, packer_out_reg: the output holding register (ovalid/dout/obe with load and transfer).

Test Plan:
- Reset held, then released, ivalid=0 -> ovalid=0, iready=1, fill=0, dout=0 throughout.
- Bytes 0x01,0x02,0x03,0x04 back-to-back, oready=1 -> dout=0x04030201, obe=4'b1111, ovalid for 1 cycle, one cycle after the 4th accept.
- Bytes 0x11,0x22 then flush pulse -> dout=0x00002211, obe=4'b0011; fill returns to 0.
- Full word pending with oready=0, then 1 more byte offered -> iready=0 and the byte is held off. oready=1 -> word transfers, byte accepted at the same edge, fill=1.
- flush with fill=0 and ivalid=0 -> no ovalid. flush with fill=3 coincident with a 4th byte 0x44 -> single word, obe=4'b1111.
- rstout_n low mid-fill (fill=2) -> fill=0 and ovalid=0 immediately. Next 4 bytes 0xA1..0xA4 -> dout=0xA4A3A2A1.
- With FIFO_WORD_PACKER_TIMEOUT_EN, one byte 0x5A then idle -> after 16 idle cycles, dout=0x0000005A, obe=4'b0001.
